// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 digest transmit path.
//   sha3_id_e    : SHA3 variant selector (224/256/384/512)
//   digest_bits  : digest length in bits for a variant
//   lane_t       : one 64-bit Keccak lane
//   CAP_BITS     : width of the capture/shift register
//   CNT_W        : beat counter width
// Optional feature macro: SHA3_TX_FULLSTATE_EN (widens capture to the full state).
package sha3_pkg;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_id_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    typedef logic [63:0] lane_t;

    localparam int LANE_BYTES = 8;
    localparam int STATE_BITS = 1600;

`ifdef SHA3_TX_FULLSTATE_EN
    localparam int CAP_BITS = STATE_BITS;
`else
    localparam int CAP_BITS = 512;
`endif

    // Sized for the longest possible stream (200 byte beats) plus one.
    localparam int CNT_W = $clog2(STATE_BITS / 8 + 1);

    function automatic int unsigned digest_bits(input sha3_id_e id);
        case (id)
            SHA3_224: return 224;
            SHA3_256: return 256;
            SHA3_384: return 384;
            default:  return 512;
        endcase
    endfunction

endpackage

// File: rtl/sha3_digest_tx_if.sv
// AXI-Stream style beat interface for the SHA3 digest output.
//   TVALID : beat valid (master -> slave)
//   TDATA  : WIDTH-bit beat data (master -> slave)
//   TLAST  : final beat marker (master -> slave)
//   TREADY : downstream accept (slave -> master)
interface sha3_digest_tx_if #(
    parameter int WIDTH = 16
) ();
    logic             TVALID;
    logic [WIDTH-1:0] TDATA;
    logic             TLAST;
    logic             TREADY;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/sha3_digest_pack.sv
// Combinational digest packer: reorders the Keccak state into digest byte order
// with byte 0 in the MSBs of the output vector, zeroing bytes beyond the digest.
//   Dout       : Keccak state, lane (x,y) = Dout[x][y]
//   id         : SHA3 variant
//   full_state : (SHA3_TX_FULLSTATE_EN only) keep all 200 state bytes
//   digest     : CAP_BITS-wide byte-ordered vector
module sha3_digest_pack
    import sha3_pkg::*;
(
    input  logic [0:4][0:4][63:0] Dout,
    input  sha3_id_e              id,
`ifdef SHA3_TX_FULLSTATE_EN
    input  logic                  full_state,
`endif
    output logic [CAP_BITS-1:0]   digest
);

    localparam int NBYTES = CAP_BITS / 8;

    logic [7:0]  keep_bytes;
    logic [24:0] lane_unused_par;
    logic        unused_lanes;

    always_comb begin
        keep_bytes = 8'(digest_bits(id) / 8);
`ifdef SHA3_TX_FULLSTATE_EN
        if (full_state) begin
            keep_bytes = 8'(STATE_BITS / 8);
        end
`endif
    end

    // Byte gi lives in lane L = gi/8 (x = L%5, y = L/5), little-endian within the lane.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign digest[CAP_BITS-1-8*gi -: 8] =
                (8'(gi) < keep_bytes) ? Dout[(gi/LANE_BYTES)%5][(gi/LANE_BYTES)/5][8*(gi%LANE_BYTES) +: 8]
                                      : 8'h00;
        end
    endgenerate

    // Lanes past the capture width are never transmitted; fold them away.
    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_lane_sink
            if (gi * LANE_BYTES >= NBYTES) begin : g_drop
                assign lane_unused_par[gi] = ^Dout[gi%5][gi/5];
            end else begin : g_keep
                assign lane_unused_par[gi] = 1'b0;
            end
        end
    endgenerate

    assign unused_lanes = ^lane_unused_par;

endmodule

// File: rtl/sha3_digest_tx.sv
// SHA3 digest transmitter: captures the final Keccak state on start and streams the
// digest as WIDTH-bit beats, first byte in the MSBs.
//   ACLK, ARESET : clock, asynchronous active-high reset
//   start, ID    : capture request and SHA3 variant (sampled together)
//   Dout         : Keccak state
//   full_state   : (SHA3_TX_FULLSTATE_EN only) stream the whole 1600-bit state
//   busy         : transfer in progress
//   axis         : beat stream (TVALID/TDATA/TLAST out, TREADY in)
// Optional feature macro: SHA3_TX_FULLSTATE_EN.
module sha3_digest_tx
    import sha3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic [1:0]            ID,
    input  logic [0:4][0:4][63:0] Dout,
`ifdef SHA3_TX_FULLSTATE_EN
    input  logic                  full_state,
`endif
    output logic                  busy,
    sha3_digest_tx_if.master      axis
);

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
            $error("sha3_digest_tx: WIDTH must be 8, 16 or 32");
        end
    endgenerate

    tx_state_e            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CNT_W-1:0]     beats_reg, beats_next;
    logic [CAP_BITS-1:0]  cap_reg, cap_next;
    logic                 tlast_reg, tlast_next;
    logic [CAP_BITS-1:0]  packed_digest;
    logic [10:0]          sel_bits;

    sha3_digest_pack u_pack (
        .Dout       (Dout),
        .id         (sha3_id_e'(ID)),
`ifdef SHA3_TX_FULLSTATE_EN
        .full_state (full_state),
`endif
        .digest     (packed_digest)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            beats_reg <= '0;
            cap_reg   <= '0;
            tlast_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            beats_reg <= beats_next;
            cap_reg   <= cap_next;
            tlast_reg <= tlast_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beats_next = beats_reg;
        cap_next   = cap_reg;
        tlast_next = tlast_reg;

        sel_bits = 11'(digest_bits(sha3_id_e'(ID)));
`ifdef SHA3_TX_FULLSTATE_EN
        if (full_state) begin
            sel_bits = 11'(STATE_BITS);
        end
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                    cnt_next   = '0;
                    beats_next = CNT_W'(sel_bits / 11'(WIDTH));
                    cap_next   = packed_digest;
                    // Shortest stream is 7 beats, so the first beat is never last.
                    tlast_next = 1'b0;
                end
            end
            SEND: begin
                if (axis.TREADY) begin
                    // The capture register is a shift register; the presented beat is its top slice.
                    cap_next = cap_reg << WIDTH;
                    if (tlast_reg) begin
                        state_next = IDLE;
                        tlast_next = 1'b0;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        tlast_next = (cnt_reg + CNT_W'(2) == beats_reg);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign axis.TVALID = (state_reg == SEND);
    assign axis.TDATA  = cap_reg[CAP_BITS-1 -: WIDTH];
    assign axis.TLAST  = tlast_reg;
    assign busy        = (state_reg == SEND);

endmodule
